serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
//   Uses a ripple of half/full-adder cells on the low digit while the operand registers shift right.
//   Ready/valid handshake on input and output. Area-cheap arithmetic for control paths where latency is acceptable.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; WIDTH >= 2
//   DIGIT  1  bits processed per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise); N = WIDTH/DIGIT
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands/mode valid
//   in_ready   out  1      block can accept operands; equals (state==IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add mode only)
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//   out_valid  out  1      result valid; equals (state==DONE)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   cout       out  1      carry out; in sub mode 1 = no borrow (a >= b unsigned)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, sum=0, cout=0, ovf=0, cnt=0, carry=0; out_valid=0, in_ready=1.
//   in_valid is ignored while rst is high.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid at an edge: capture a into a_sh, and b (or ~b when sub=1) into b_sh.
//     - Load carry = sub ? 1 : cin; load cnt=0; go to RUN.
//   RUN:
//     - in_ready=0, out_valid=0.
//     - Each edge: {c,s} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
//     - carry<=c; a_sh and b_sh shift right by DIGIT; s is shifted into sum from the MSB end.
//     - On the last digit (cnt==N-1), record the carry into the MSB for ovf.
//     - After N edges: cout<=final carry, ovf<=cMSBin^cout; go to DONE.
//   DONE:
//     - out_valid=1; sum/cout/ovf held stable.
//     - On out_ready at an edge: go to IDLE. sum/cout/ovf keep their values until the next accept.
//   Latency: operands accepted at edge k -> out_valid high after edge k+N.
//   Minimum issue interval: N+2 cycles. No accept in the same cycle as result handoff, because in_ready is only high in IDLE.
//   sum is a register. It may show partial values while out_valid=0; consumers sample it only when out_valid=1.
//   Backpressure: DONE holds indefinitely with out_ready=0; in_valid is ignored meanwhile.
//   Reset mid-RUN or mid-DONE: the operation is aborted, no out_valid pulse, all outputs at reset values.
//   Wrap-around: results are modulo 2^WIDTH; the carry/borrow appears only on cout.
//   Only cnt (clog2(N) bits, minimum 1) counts cycles.
// TESTING (WIDTH=8, DIGIT=1 unless noted)
//   1. add 0x3C+0x0F, cin=0 -> sum=0x4B, cout=0, ovf=0; out_valid rises exactly 8 cycles after accept.
//   2. add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x7F+0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
//   3. sub 0x05-0x07, cin=1 (ignored) -> sum=0xFE, cout=0, ovf=0. Sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
//   4. Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
//      -> sum/out_valid stable, in_ready=0, no capture.
//      Then out_ready=1 -> IDLE next edge; new operands accepted one cycle later.
//   5. Assert rst 3 cycles into RUN -> out_valid=0, in_ready=1, sum=0, cout=0, ovf=0 immediately.
//      No result appears; a fresh op after release completes normally.
//   6. DIGIT=4: add 0x99+0x67 -> sum=0x00, cout=1, out_valid 2 cycles after accept.
//      Back-to-back random ops with random out_ready are checked against a reference model.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder: multi-cycle adder/subtractor, DIGIT bits per clock.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;
  logic [WIDTH-1:0] sum_next;

  // Ripple of full-adder cells over the low digit of the shift registers.
  assign c[0] = carry;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      assign s[i]   = a_sh[i] ^ b_sh[i] ^ c[i];
      assign c[i+1] = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
  endgenerate

  generate
    if (N == 1) begin : g_sum_full
      assign sum_next = s;
    end else begin : g_sum_shift
      assign sum_next = {s, sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c[DIGIT];
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          sum   <= sum_next;
          cnt   <= cnt + 1'b1;
          // On the top digit c[DIGIT-1] is the carry into the result MSB.
          if (cnt == CW'(N - 1)) begin
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT-1] ^ c[DIGIT];
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder: WIDTH=8 with DIGIT=1 and DIGIT=4, scoreboard vs arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [7:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0, sub1 = 1'b0, cout1, ovf1;

  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [7:0] a4 = '0, b4 = '0, sum4;
  logic       cin4 = 1'b0, sub4 = 1'b0, cout4, ovf4;

  int checks = 0;
  int passes = 0;

  logic [9:0] q1[$];
  logic [9:0] q4[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Reference: {cout, ovf, sum} from plain two's-complement arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] r;
    logic       v;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
    v  = (a[7] == bb[7]) && (r[7] != a[7]);
    return {r[8], v, r[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compare each handed-off result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("d1_unexpected_result", 32'd1, 32'd0);
      else chk("d1_result", {22'd0, cout1, ovf1, sum1}, {22'd0, q1.pop_front()});
    end
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) chk("d4_unexpected_result", 32'd1, 32'd0);
      else chk("d4_result", {22'd0, cout4, ovf4, sum4}, {22'd0, q4.pop_front()});
    end
  end

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int t;
    t = 0;
    in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = cin; sub1 = sub;
    while (!in_ready1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("d1_accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      q1.push_back(model(a, b, cin, sub));
    end
    in_valid1 = 1'b0;
  endtask

  task automatic issue4(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int t;
    t = 0;
    in_valid4 = 1'b1; a4 = a; b4 = b; cin4 = cin; sub4 = sub;
    while (!in_ready4 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("d4_accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      q4.push_back(model(a, b, cin, sub));
    end
    in_valid4 = 1'b0;
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid1 && n < 40);
  endtask

  task automatic wait_valid4(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid4 && n < 40);
  endtask

  initial begin
    int  n;
    int  seen;
    bit  done1, done4;

    // Reset values are visible before any clock edge.
    #1;
    chk("rst_sum",       {24'd0, sum1}, 32'd0);
    chk("rst_cout_ovf",  {30'd0, cout1, ovf1}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready1}, 32'd1);
    chk("rst_in_ready4", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic add with latency measurement.
    issue1(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_valid1(n);
    chk("d1_latency", n, 32'd8);

    issue1(8'hFF, 8'h01, 1'b0, 1'b0);
    issue1(8'h7F, 8'h00, 1'b1, 1'b0);
    issue1(8'h05, 8'h07, 1'b1, 1'b1);
    issue1(8'h80, 8'h01, 1'b0, 1'b1);
    wait_valid1(n);
    @(posedge clk); #1;

    // Backpressure in DONE while new operands are offered.
    out_ready1 = 1'b0;
    issue1(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid1(n);
    in_valid1 = 1'b1; a1 = 8'hAA; b1 = 8'h55; cin1 = 1'b1; sub1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid1}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready1}, 32'd0);
      chk("bp_sum",       {24'd0, sum1}, 32'h46);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready",  {31'd0, in_ready1}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("bp_idle_sum_held",  {24'd0, sum1}, 32'h46);
    q1.push_back(model(8'hAA, 8'h55, 1'b1, 1'b0));
    @(posedge clk); #1;
    chk("bp_new_accept", {31'd0, in_ready1}, 32'd0);
    in_valid1 = 1'b0;
    wait_valid1(n);
    @(posedge clk); #1;

    // Reset three cycles into RUN aborts the operation.
    issue1(8'h21, 8'h43, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready1}, 32'd1);
    chk("abort_sum",       {24'd0, sum1}, 32'd0);
    chk("abort_cout_ovf",  {30'd0, cout1, ovf1}, 32'd0);
    void'(q1.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid1) seen++; end
    chk("abort_no_result", seen, 32'd0);
    issue1(8'h9C, 8'h2B, 1'b0, 1'b1);
    wait_valid1(n);
    chk("post_abort_latency", n, 32'd8);

    // DIGIT=4 directed case.
    issue4(8'h99, 8'h67, 1'b0, 1'b0);
    wait_valid4(n);
    chk("d4_latency", n, 32'd2);
    @(posedge clk); #1;

    // Random back-to-back traffic with random consumer backpressure.
    done1 = 1'b0; done4 = 1'b0;
    fork
      begin
        repeat (40) issue1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        done1 = 1'b1;
      end
      begin
        repeat (60) issue4(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        done4 = 1'b1;
      end
      begin
        while (!(done1 && done4)) begin
          @(posedge clk); #1;
          out_ready1 = 1'($urandom_range(0, 1));
          out_ready4 = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready1 = 1'b1; out_ready4 = 1'b1;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("d1_drained", q1.size(), 32'd0);
    chk("d4_drained", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
